// File: rtl/formant_freq_tracker_if.sv
// Formant tracker bus: phi frame input, smoothing control, and result handshake.
// Latency: none, this is wiring only.
// Backpressure: out_ready_in from the consumer; the phi side has no ready and relies on drop counting.
interface formant_freq_tracker_if #(
   parameter int FREQ_WIDTH = 16
);
   logic [31:0]           phi_1_in;
   logic [31:0]           phi_2_in;
   logic [31:0]           phi_3_in;
   logic [31:0]           phi_4_in;
   logic [31:0]           phi_5_in;
   logic                  phi_valid_in;
   logic                  smooth_clr_in;
   logic                  out_ready_in;
   logic [FREQ_WIDTH-1:0] freq_1_out;
   logic [FREQ_WIDTH-1:0] freq_2_out;
   logic [FREQ_WIDTH-1:0] freq_3_out;
   logic [FREQ_WIDTH-1:0] freq_4_out;
   logic [FREQ_WIDTH-1:0] freq_5_out;
   logic                  out_valid;
   logic                  busy_out;
   logic [7:0]            drop_count;

   // Tracker side
   modport slave (
      input  phi_1_in, phi_2_in, phi_3_in, phi_4_in, phi_5_in,
      input  phi_valid_in, smooth_clr_in, out_ready_in,
      output freq_1_out, freq_2_out, freq_3_out, freq_4_out, freq_5_out,
      output out_valid, busy_out, drop_count
   );

   // Producer/consumer side
   modport master (
      output phi_1_in, phi_2_in, phi_3_in, phi_4_in, phi_5_in,
      output phi_valid_in, smooth_clr_in, out_ready_in,
      input  freq_1_out, freq_2_out, freq_3_out, freq_4_out, freq_5_out,
      input  out_valid, busy_out, drop_count
   );
endinterface

// File: rtl/formant_freq_tracker.sv
// Converts five formant angles to Hz, sorts them ascending and smooths each slot against the last frame.
// Latency: out_valid rises after the 20th edge following the edge that accepts the frame.
// Backpressure: result held until out_ready_in; frames arriving while busy are dropped and counted.
module formant_freq_tracker #(
   parameter int FORMANTS    = 5,
   parameter int MAX_FREQ    = 5000,
   parameter int FREQ_WIDTH  = 16,
   parameter int ALPHA_SHIFT = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   formant_freq_tracker_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_SCALE, S_SORT, S_SMOOTH, S_OUTPUT} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [15:0]           phi_q   [FORMANTS];
   logic [FREQ_WIDTH-1:0] f_q     [FORMANTS];
   logic [FREQ_WIDTH-1:0] y_q     [FORMANTS];
   logic [FREQ_WIDTH-1:0] freq_q  [FORMANTS];
   logic                  out_valid_q;
   logic                  first_q;
   logic                  use_first_q;
   logic [7:0]            drop_q;

   logic                    accept;
   logic                    last_smooth;
   logic [2:0]              slot;
   logic [2:0]              sort_a, sort_b;
   logic [31:0]             prod;
   logic [FREQ_WIDTH-1:0]   scaled;
   logic signed [FREQ_WIDTH:0] diff, diff_sh, sum;
   logic [FREQ_WIDTH-1:0]   y_new;

   // Only the top 16 bits of each angle carry weight in the Hz conversion.
   logic unused_phi_lsbs;
   assign unused_phi_lsbs = ^{bus.phi_1_in[15:0], bus.phi_2_in[15:0], bus.phi_3_in[15:0],
                              bus.phi_4_in[15:0], bus.phi_5_in[15:0]};

   assign accept      = (state_q == S_IDLE) && bus.phi_valid_in;
   assign last_smooth = (state_q == S_SMOOTH) && (cnt_q == 4'd4);
   assign slot        = cnt_q[2:0];

   // Next-state logic: fixed-length SCALE/SORT/SMOOTH phases, OUTPUT waits for the handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:   if (bus.phi_valid_in) begin state_d = S_SCALE; cnt_d = 4'd0; end
         S_SCALE:  if (cnt_q == 4'd4) begin state_d = S_SORT; cnt_d = 4'd0; end
                   else cnt_d = cnt_q + 4'd1;
         S_SORT:   if (cnt_q == 4'd9) begin state_d = S_SMOOTH; cnt_d = 4'd0; end
                   else cnt_d = cnt_q + 4'd1;
         S_SMOOTH: if (cnt_q == 4'd4) begin state_d = S_OUTPUT; cnt_d = 4'd0; end
                   else cnt_d = cnt_q + 4'd1;
         S_OUTPUT: if (out_valid_q && bus.out_ready_in) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath helpers: shared multiplier, sorting-network pair select, smoothing step.
   always_comb begin
      prod   = 32'(phi_q[slot]) * 32'(MAX_FREQ);
      scaled = FREQ_WIDTH'(prod >> 16);
      case (cnt_q)
         4'd1, 4'd5, 4'd8: sort_a = 3'd1;
         4'd2, 4'd6:       sort_a = 3'd2;
         4'd3:             sort_a = 3'd3;
         default:          sort_a = 3'd0;
      endcase
      sort_b  = sort_a + 3'd1;
      diff    = $signed({1'b0, f_q[slot]}) - $signed({1'b0, y_q[slot]});
      diff_sh = diff >>> ALPHA_SHIFT;
      sum     = $signed({1'b0, y_q[slot]}) + diff_sh;
      y_new   = use_first_q ? f_q[slot] : sum[FREQ_WIDTH-1:0];
   end

   // Control state: FSM, handshake flag, drop counter and first-frame bookkeeping.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         out_valid_q <= 1'b0;
         drop_q      <= 8'd0;
         first_q     <= 1'b1;
         use_first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (last_smooth)
            out_valid_q <= 1'b1;
         else if ((state_q == S_OUTPUT) && bus.out_ready_in)
            out_valid_q <= 1'b0;
         if (bus.phi_valid_in && (state_q != S_IDLE) && (drop_q != 8'hFF))
            drop_q <= drop_q + 8'd1;
         // The accepted frame consumes any pending clear; a clear seen later waits for the next frame.
         if (accept) begin
            use_first_q <= first_q | bus.smooth_clr_in;
            first_q     <= 1'b0;
         end else if (bus.smooth_clr_in) begin
            first_q <= 1'b1;
         end
      end
   end

   // Data registers: capture, scale, compare-exchange, smooth and publish.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < FORMANTS; i++) begin
            phi_q[i]  <= '0;
            f_q[i]    <= '0;
            y_q[i]    <= '0;
            freq_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            phi_q[0] <= bus.phi_1_in[31:16];
            phi_q[1] <= bus.phi_2_in[31:16];
            phi_q[2] <= bus.phi_3_in[31:16];
            phi_q[3] <= bus.phi_4_in[31:16];
            phi_q[4] <= bus.phi_5_in[31:16];
         end
         if (state_q == S_SCALE)
            f_q[slot] <= scaled;
         if ((state_q == S_SORT) && (f_q[sort_a] > f_q[sort_b])) begin
            f_q[sort_a] <= f_q[sort_b];
            f_q[sort_b] <= f_q[sort_a];
         end
         if (state_q == S_SMOOTH)
            y_q[slot] <= y_new;
         if (last_smooth) begin
            for (int i = 0; i < FORMANTS; i++)
               freq_q[i] <= (i == int'(slot)) ? y_new : y_q[i];
         end
      end
   end

   assign bus.freq_1_out = freq_q[0];
   assign bus.freq_2_out = freq_q[1];
   assign bus.freq_3_out = freq_q[2];
   assign bus.freq_4_out = freq_q[3];
   assign bus.freq_5_out = freq_q[4];
   assign bus.out_valid  = out_valid_q;
   assign bus.busy_out   = (state_q != S_IDLE);
   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_formant_freq_tracker.sv
// Bench for formant_freq_tracker: directed scenarios followed by randomized frames against a reference model.
// Latency: checks the 20-edge frame latency on every frame.
// Backpressure: holds out_ready_in low with extra frames to exercise dropping and saturation.
module tb_formant_freq_tracker;
   localparam int FW    = 16;
   localparam int ALPHA = 2;
   localparam int MAXF  = 5000;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   always #5 clk_in = ~clk_in;

   formant_freq_tracker_if #(.FREQ_WIDTH(FW)) bus ();

   formant_freq_tracker #(
      .FORMANTS(5), .MAX_FREQ(MAXF), .FREQ_WIDTH(FW), .ALPHA_SHIFT(ALPHA)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [31:0] phi_v [5];
   int          y_m   [5];
   bit          first_m = 1'b1;
   int          drop_m  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic int floor_div(input int n, input int d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   // Frame model: Hz conversion, ascending order, exponential smoothing.
   task automatic model_frame(input bit clr);
      int q[$];
      for (int i = 0; i < 5; i++)
         q.push_back(int'((longint'(phi_v[i] >> 16) * MAXF) / 65536));
      q.sort();
      for (int i = 0; i < 5; i++) begin
         if (first_m || clr) y_m[i] = q[i];
         else                y_m[i] = y_m[i] + floor_div(q[i] - y_m[i], 1 << ALPHA);
      end
      first_m = 1'b0;
   endtask

   task automatic drive_phi();
      bus.phi_1_in = phi_v[0];
      bus.phi_2_in = phi_v[1];
      bus.phi_3_in = phi_v[2];
      bus.phi_4_in = phi_v[3];
      bus.phi_5_in = phi_v[4];
   endtask

   task automatic check_freqs(input string tag);
      check({tag, " freq_1"}, 32'(bus.freq_1_out), y_m[0]);
      check({tag, " freq_2"}, 32'(bus.freq_2_out), y_m[1]);
      check({tag, " freq_3"}, 32'(bus.freq_3_out), y_m[2]);
      check({tag, " freq_4"}, 32'(bus.freq_4_out), y_m[3]);
      check({tag, " freq_5"}, 32'(bus.freq_5_out), y_m[4]);
      check({tag, " drop_count"}, 32'(bus.drop_count), drop_m);
   endtask

   // Present a frame for one cycle and wait (bounded) for the result.
   task automatic send_frame(input string tag, input bit clr);
      int lat;
      drive_phi();
      bus.phi_valid_in  = 1'b1;
      bus.smooth_clr_in = clr;
      tick();
      bus.phi_valid_in  = 1'b0;
      bus.smooth_clr_in = 1'b0;
      model_frame(clr);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, 20);
      check({tag, " busy"}, 32'(bus.busy_out), 1);
      check_freqs(tag);
   endtask

   task automatic handshake(input string tag, input bit with_phi);
      bus.out_ready_in = 1'b1;
      bus.phi_valid_in = with_phi;
      tick();
      bus.out_ready_in = 1'b0;
      bus.phi_valid_in = 1'b0;
      if (with_phi && drop_m < 255) drop_m++;
      check({tag, " valid after handshake"}, 32'(bus.out_valid), 0);
      check({tag, " busy after handshake"}, 32'(bus.busy_out), 0);
      check({tag, " drop after handshake"}, 32'(bus.drop_count), drop_m);
   endtask

   initial begin
      bus.phi_valid_in  = 1'b0;
      bus.smooth_clr_in = 1'b0;
      bus.out_ready_in  = 1'b0;
      for (int i = 0; i < 5; i++) phi_v[i] = '0;
      drive_phi();

      // Reset state
      #12;
      check("reset out_valid", 32'(bus.out_valid), 0);
      check("reset busy", 32'(bus.busy_out), 0);
      check("reset drop_count", 32'(bus.drop_count), 0);
      check("reset freq_1", 32'(bus.freq_1_out), 0);
      check("reset freq_5", 32'(bus.freq_5_out), 0);
      rst_in = 1'b1;
      tick();

      // Unsorted first frame
      phi_v[0] = 32'h8000_0000; phi_v[1] = 32'h2000_0000; phi_v[2] = 32'hFFFF_FF00;
      phi_v[3] = 32'h4000_0000; phi_v[4] = 32'hC000_00A0;
      send_frame("first", 1'b0);
      check("first const f1", 32'(bus.freq_1_out), 625);
      check("first const f5", 32'(bus.freq_5_out), 4999);
      handshake("first", 1'b0);

      // Smoothing against the first frame
      for (int i = 0; i < 5; i++) phi_v[i] = 32'h4000_0000;
      send_frame("smooth", 1'b0);
      check("smooth const f1", 32'(bus.freq_1_out), 781);
      check("smooth const f3", 32'(bus.freq_3_out), 2187);
      check("smooth const f5", 32'(bus.freq_5_out), 4061);

      // Backpressure with two dropped frames
      for (int c = 0; c < 10; c++) begin
         bus.phi_valid_in = (c == 3 || c == 7);
         if (bus.phi_valid_in) drop_m++;
         tick();
         bus.phi_valid_in = 1'b0;
         check($sformatf("backpressure valid c%0d", c), 32'(bus.out_valid), 1);
         check($sformatf("backpressure f3 c%0d", c), 32'(bus.freq_3_out), y_m[2]);
      end
      check("backpressure drop_count", 32'(bus.drop_count), 2);
      handshake("backpressure", 1'b0);

      // Smooth clear on top of existing history
      for (int i = 0; i < 5; i++) phi_v[i] = 32'h2000_0000;
      send_frame("clear", 1'b1);
      check("clear const f2", 32'(bus.freq_2_out), 625);
      check("clear const f4", 32'(bus.freq_4_out), 625);
      handshake("clear phi on handshake edge", 1'b1);

      // Async reset during SORT
      for (int i = 0; i < 5; i++) phi_v[i] = $urandom;
      drive_phi();
      bus.phi_valid_in = 1'b1;
      tick();
      bus.phi_valid_in = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      #2 rst_in = 1'b0;
      #1;
      check("async reset out_valid", 32'(bus.out_valid), 0);
      check("async reset busy", 32'(bus.busy_out), 0);
      check("async reset freq_1", 32'(bus.freq_1_out), 0);
      check("async reset freq_5", 32'(bus.freq_5_out), 0);
      check("async reset drop_count", 32'(bus.drop_count), 0);
      for (int i = 0; i < 5; i++) y_m[i] = 0;
      first_m = 1'b1;
      drop_m  = 0;
      #2 rst_in = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) phi_v[i] = $urandom;
      send_frame("post reset", 1'b0);
      handshake("post reset", 1'b0);

      // Randomized frames, random consumer delay, drops and clears while busy
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 5; i++) begin
            phi_v[i] = $urandom;
            if ($urandom_range(0, 5) == 0) phi_v[i] = phi_v[(i + 1) % 5];
         end
         send_frame($sformatf("rand%0d", n), $urandom_range(0, 3) == 0);
         for (int c = $urandom_range(0, 3); c > 0; c--) begin
            bus.phi_valid_in  = $urandom_range(0, 1);
            bus.smooth_clr_in = ($urandom_range(0, 5) == 0);
            if (bus.phi_valid_in && drop_m < 255) drop_m++;
            if (bus.smooth_clr_in) first_m = 1'b1;
            tick();
            bus.phi_valid_in  = 1'b0;
            bus.smooth_clr_in = 1'b0;
         end
         check_freqs($sformatf("rand%0d held", n));
         handshake($sformatf("rand%0d", n), $urandom_range(0, 1));
      end

      // Drop counter saturation
      for (int i = 0; i < 5; i++) phi_v[i] = $urandom;
      send_frame("saturate", 1'b0);
      for (int c = 0; c < 300; c++) begin
         bus.phi_valid_in = 1'b1;
         tick();
      end
      bus.phi_valid_in = 1'b0;
      drop_m = 255;
      check("saturate drop_count", 32'(bus.drop_count), 255);
      check_freqs("saturate held");
      handshake("saturate", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/formant_freq_tracker.md
Name: formant_freq_tracker

Overview:
- Sits directly downstream of the phi (formant angle) stage.
- On each phi frame pulse it captures the five 32-bit formant angles and converts each to Hz.
- It sorts the five frequencies ascending, then applies per-slot exponential smoothing against the previous frame.
- It presents the result to the display/synthesis consumer over a valid/ready handshake.

Parameters:
- FORMANTS, 5, number of formant slots; the design is fixed at 5, and the parameter exists for checking only.
- MAX_FREQ, 5000, Nyquist frequency in Hz; a phi of full-scale 2^32 corresponds to pi rad, which is MAX_FREQ.
- FREQ_WIDTH, 16, width of each frequency output.
- ALPHA_SHIFT, 2, smoothing coefficient 2^-ALPHA_SHIFT; a value of 0 disables smoothing.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- phi_1_in..phi_5_in  input  32 each  unsigned angles from the phi stage, unordered
- phi_valid_in  input  1  one-cycle pulse; the phi inputs are valid in that cycle
- smooth_clr_in  input  1  pulse; the next accepted frame loads without smoothing
- out_ready_in  input  1  consumer ready
- freq_1_out..freq_5_out  output  FREQ_WIDTH each  smoothed Hz, freq_1 lowest
- out_valid  output  1  result valid; held until accepted
- busy_out  output  1  high in every state except IDLE
- drop_count  output  8  saturating count of frames dropped while busy

Behaviour:
- Reset (rst_in low, async):
  - state goes to IDLE; all freq outputs, out_valid and drop_count go to 0.
  - first_frame flag is set to 1; capture, working and history registers are cleared.
- State machine: IDLE -> SCALE -> SORT -> SMOOTH -> OUTPUT -> IDLE.
- IDLE:
  - phi_valid_in high: capture all five phi values, go to SCALE.
  - smooth_clr_in high in any state: set first_frame; this is sticky until consumed by a frame.
- SCALE, 5 cycles, one shared multiplier:
  - f[i] = (phi_i[31:16] * MAX_FREQ) >> 16, unsigned.
  - Result range is 0..MAX_FREQ-1 and is zero-extended to FREQ_WIDTH.
- SORT, exactly 10 cycles:
  - One compare-exchange per cycle on pairs (0,1),(1,2),(2,3),(3,4),(0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
  - Swap when f[a] > f[b]; ties do not swap.
- SMOOTH, 5 cycles, slot i per cycle:
  - first_frame=1: y[i] = f[i].
  - first_frame=0: y[i] = y[i] + ((f[i] - y[i]) >>> ALPHA_SHIFT).
  - The difference is signed FREQ_WIDTH+1 bits; the arithmetic shift rounds toward minus infinity.
  - The result always lies within [min(y,f), max(y,f)], so no overflow is possible.
  - On the last slot: clear first_frame, copy y into freq outputs, assert out_valid, go to OUTPUT.
- Latency: out_valid is high after the 20th rising edge following the edge that sampled phi_valid_in.
  - Capture is at edge 0, SCALE at 1-5, SORT at 6-15, SMOOTH at 16-20.
- OUTPUT:
  - out_valid and freq outputs are held stable.
  - On an edge with out_valid && out_ready_in: deassert out_valid, go to IDLE.
  - out_ready_in high on the first OUTPUT cycle gives a one-cycle out_valid.
- Frame accept and drop:
  - A frame is accepted only in IDLE.
  - phi_valid_in in any other state, including the handshake edge of OUTPUT, is dropped.
  - A dropped frame increments drop_count, saturating at 255; state, history and outputs are unaffected.
- smooth_clr_in coinciding with phi_valid_in in IDLE: that same frame loads unsmoothed.
- freq outputs change only at the SMOOTH->OUTPUT transition, or on reset.

Test Plan:
- Unsorted first frame: after reset, phi_1..5 = 0x80000000, 0x20000000, 0xFFFFFF00, 0x40000000, 0xC00000A0 -> out_valid 20 cycles later with freq_1..5 = 625, 1250, 2500, 3750, 4999; drop_count = 0.
- Smoothing, continuing from the first scenario with ALPHA_SHIFT=2: all five phi = 0x40000000 (1250 Hz) -> freq = 781, 1250, 2187, 3125, 4061.
- Backpressure and drop: hold out_ready_in low for 10 cycles with out_valid high, and pulse phi_valid_in twice -> outputs stay constant, drop_count = 2, then a ready pulse gives one handshake and a return to IDLE.
- Async reset mid-operation: assert rst_in low during cycle 8 (SORT) -> outputs and out_valid are 0 immediately without a clock edge; the next frame is treated as first (unsmoothed).
- Smooth clear: the history from the second scenario is present, then smooth_clr_in is pulsed together with a frame of all 0x20000000 -> all outputs = 625.
- Drop saturation: hold OUTPUT with ready low and pulse phi_valid_in 300 times -> drop_count = 255.
